fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 29 ++
 rtl/fetch_sequencer.sv | 92 +++++++++
 2 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its decoder.
package fetch_sequencer_pkg;

  localparam int DEF_PC_W    = 12;
  localparam int DEF_INSTR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_HALT
  } fs_state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_SET  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_MULT = 4'h4;
  localparam logic [3:0] OP_JNZ  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;

  // The upper half of the opcode space is reserved.
  function automatic logic op_is_illegal(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer: fetches instruction words, holds them in IR
// and strobes exec_en once per executed instruction.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         opcode,
  output logic [PC_W-1:0]    operand,
  input  logic               pc_load,
  output logic               exec_en,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               illegal
);

  fs_state_e          state, state_nxt;
  logic [INSTR_W-1:0] ir, ir_nxt;
  logic [PC_W-1:0]    pc_nxt;
  logic               illegal_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      illegal <= illegal_nxt;
    end
  end

  // Strobes decode straight from state so reset kills them in the same cycle.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    illegal_nxt = illegal;
    imem_req    = 1'b0;
    exec_en     = 1'b0;
    halted      = 1'b0;
    unique case (state)
      ST_IDLE, ST_HALT: begin
        halted = (state == ST_HALT);
        if (start) begin
          pc_nxt      = '0;
          illegal_nxt = 1'b0;
          state_nxt   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_nxt    = imem_rdata;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_NOP) begin
          state_nxt = ST_HALT;
        end else if (op_is_illegal(opcode)) begin
          illegal_nxt = 1'b1;
          state_nxt   = ST_HALT;
        end else begin
          state_nxt = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        exec_en   = 1'b1;
        pc_nxt    = pc_load ? operand : pc + PC_W'(1);
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign imem_addr = pc;
  assign opcode    = ir[INSTR_W-1 -: 4];
  assign operand   = ir[PC_W-1:0];

endmodule
